// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive end of a 4-slot TDM link.
// Recovers slots a,b,c,d from a serial stream. A frame marker flags slot 0.
// A complete frame is presented as four registered words, with a one-cycle
// valid strobe.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          sample enable (low: state holds, strobes drop)
//   frame       high when din carries slot 0
//   din[W-1:0]  serial slot data
//   a,b,c,d     recovered slot 0..3 words
//   s1,s0       index of the slot expected at the next sample
//   valid       one-cycle pulse: a..d updated at the previous edge
//   locked      high while in LOCK
//   err         one-cycle pulse on a framing error
//
// Build option: TDM_DEMUX_FRAME_CHECK_EN
//   defined   -> a slot-0 sample without frame drops lock (err, back to HUNT)
//   undefined -> flywheel: a slot-0 sample without frame is accepted as slot 0
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         frame,
  input  logic [W-1:0] din,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         s1,
  output logic         s0,
  output logic         valid,
  output logic         locked,
  output logic         err
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t       r_state;
  logic [1:0]   r_idx;
  logic [W-1:0] r_sh0, r_sh1, r_sh2;
  logic [W-1:0] r_a, r_b, r_c, r_d;
  logic         r_valid, r_locked, r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= HUNT;
      r_idx    <= '0;
      r_sh0    <= '0;
      r_sh1    <= '0;
      r_sh2    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (en) begin
        case (r_state)
          HUNT: begin
            if (frame) begin
              r_sh0    <= din;
              r_idx    <= 2'd1;
              r_state  <= LOCK;
              r_locked <= 1'b1;
            end
          end
          LOCK: begin
            if (frame) begin
              // A marker always restarts the frame at slot 0. A marker seen
              // at any other slot aborts the partial frame.
              if (r_idx != 2'd0) r_err <= 1'b1;
              r_sh0 <= din;
              r_idx <= 2'd1;
            end else begin
              case (r_idx)
                2'd0: begin
`ifdef TDM_DEMUX_FRAME_CHECK_EN
                  r_err    <= 1'b1;
                  r_state  <= HUNT;
                  r_locked <= 1'b0;
                  r_idx    <= 2'd0;
`else
                  r_sh0 <= din;
                  r_idx <= 2'd1;
`endif
                end
                2'd1: begin
                  r_sh1 <= din;
                  r_idx <= 2'd2;
                end
                2'd2: begin
                  r_sh2 <= din;
                  r_idx <= 2'd3;
                end
                default: begin
                  // Slot 3 goes straight to d, so all four words update together.
                  r_a     <= r_sh0;
                  r_b     <= r_sh1;
                  r_c     <= r_sh2;
                  r_d     <= din;
                  r_valid <= 1'b1;
                  r_idx   <= 2'd0;
                end
              endcase
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign a      = r_a;
  assign b      = r_b;
  assign c      = r_c;
  assign d      = r_d;
  assign s1     = r_idx[1];
  assign s0     = r_idx[0];
  assign valid  = r_valid;
  assign locked = r_locked;
  assign err    = r_err;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       frame = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] a, b, c, d;
  logic       s1, s0, valid, locked, err;

  int n_total = 0;
  int n_pass  = 0;

  tdm_demux4 #(.W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .frame(frame), .din(din),
    .a(a), .b(b), .c(c), .d(d),
    .s1(s1), .s0(s0), .valid(valid), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ea, eb, ec, ed);
    chk({tag, ".abcd"}, {16'h0, a, b, c, d}, {16'h0, ea, eb, ec, ed});
  endtask

  task automatic chk_st(input string tag, input logic [1:0] es, input logic ev, el, ee);
    chk({tag, ".idx"},    {30'h0, s1, s0}, {30'h0, es});
    chk({tag, ".valid"},  {31'h0, valid},  {31'h0, ev});
    chk({tag, ".locked"}, {31'h0, locked}, {31'h0, el});
    chk({tag, ".err"},    {31'h0, err},    {31'h0, ee});
  endtask

  // Drive one clock with the given inputs and sample #1 after the edge.
  task automatic step(input logic e, input logic f, input logic [3:0] dd);
    en = e; frame = f; din = dd;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset for two cycles
    rst = 1'b1;
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    chk_out("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    chk_st("reset", 2'd0, 0, 0, 0);
    rst = 1'b0;

    // Acquire 1,2,3,4
    step(1, 1, 4'h1); chk_st("acq0", 2'd1, 0, 1, 0);
    step(1, 0, 4'h2); chk_st("acq1", 2'd2, 0, 1, 0);
    step(1, 0, 4'h3); chk_st("acq2", 2'd3, 0, 1, 0);
                      chk_out("acq2", 4'h0, 4'h0, 4'h0, 4'h0);
    step(1, 0, 4'h4); chk_st("acq3", 2'd0, 1, 1, 0);
                      chk_out("acq3", 4'h1, 4'h2, 4'h3, 4'h4);
    step(0, 1, 4'h9); chk_st("acq_idle", 2'd0, 0, 1, 0);
                      chk_out("acq_idle", 4'h1, 4'h2, 4'h3, 4'h4);

    // Back to HUNT, din discarded without frame
    rst = 1'b1;
    step(0, 0, 4'h0);
    rst = 1'b0;
    chk_out("rst2", 4'h0, 4'h0, 4'h0, 4'h0);
    chk_st("rst2", 2'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'hF);
      chk_st("hunt", 2'd0, 0, 0, 0);
    end
    chk_out("hunt", 4'h0, 4'h0, 4'h0, 4'h0);

    // Frame 5,6,7,8 stretched by an en gap between slots 1 and 2
    step(1, 1, 4'h5); chk_st("gap0", 2'd1, 0, 1, 0);
    step(1, 0, 4'h6); chk_st("gap1", 2'd2, 0, 1, 0);
    step(0, 1, 4'hE); chk_st("gapA", 2'd2, 0, 1, 0);
    step(0, 0, 4'hD); chk_st("gapB", 2'd2, 0, 1, 0);
    step(1, 0, 4'h7); chk_st("gap2", 2'd3, 0, 1, 0);
    step(1, 0, 4'h8); chk_st("gap3", 2'd0, 1, 1, 0);
                      chk_out("gap3", 4'h5, 4'h6, 4'h7, 4'h8);
    step(0, 0, 4'h0); chk_st("gap_post", 2'd0, 0, 1, 0);

    // Early frame at slot 2 aborts the partial frame
    step(1, 1, 4'h1); chk_st("early0", 2'd1, 0, 1, 0);
    step(1, 0, 4'h2); chk_st("early1", 2'd2, 0, 1, 0);
    step(1, 1, 4'h9); chk_st("early_err", 2'd1, 0, 1, 1);
                      chk_out("early_err", 4'h5, 4'h6, 4'h7, 4'h8);
    step(1, 0, 4'hA); chk_st("early_a", 2'd2, 0, 1, 0);
    step(1, 0, 4'hB); chk_st("early_b", 2'd3, 0, 1, 0);
                      chk_out("early_b", 4'h5, 4'h6, 4'h7, 4'h8);
    step(1, 0, 4'hC); chk_st("early_c", 2'd0, 1, 1, 0);
                      chk_out("early_c", 4'h9, 4'hA, 4'hB, 4'hC);

    // Missing frame: marker only on the first of 8 samples
    step(1, 1, 4'h1); chk_st("miss1", 2'd1, 0, 1, 0);
    step(1, 0, 4'h2); chk_st("miss2", 2'd2, 0, 1, 0);
    step(1, 0, 4'h3); chk_st("miss3", 2'd3, 0, 1, 0);
    step(1, 0, 4'h4); chk_st("miss4", 2'd0, 1, 1, 0);
                      chk_out("miss4", 4'h1, 4'h2, 4'h3, 4'h4);
`ifdef TDM_DEMUX_FRAME_CHECK_EN
    step(1, 0, 4'h5); chk_st("miss5", 2'd0, 0, 0, 1);
    step(1, 0, 4'h6); chk_st("miss6", 2'd0, 0, 0, 0);
    step(1, 0, 4'h7); chk_st("miss7", 2'd0, 0, 0, 0);
    step(1, 0, 4'h8); chk_st("miss8", 2'd0, 0, 0, 0);
                      chk_out("miss8", 4'h1, 4'h2, 4'h3, 4'h4);
`else
    step(1, 0, 4'h5); chk_st("miss5", 2'd1, 0, 1, 0);
    step(1, 0, 4'h6); chk_st("miss6", 2'd2, 0, 1, 0);
    step(1, 0, 4'h7); chk_st("miss7", 2'd3, 0, 1, 0);
    step(1, 0, 4'h8); chk_st("miss8", 2'd0, 1, 1, 0);
                      chk_out("miss8", 4'h5, 4'h6, 4'h7, 4'h8);
`endif

    // Reset mid-frame
    step(1, 1, 4'h3); chk_st("mid0", 2'd1, 0, 1, 0);
    step(1, 0, 4'h4); chk_st("mid1", 2'd2, 0, 1, 0);
    rst = 1'b1;
    step(1, 0, 4'h5);
    rst = 1'b0;
    chk_out("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk_st("mid_rst", 2'd0, 0, 0, 0);
    step(1, 0, 4'h6); chk_st("mid_h1", 2'd0, 0, 0, 0);
    step(1, 0, 4'h7); chk_st("mid_h2", 2'd0, 0, 0, 0);
    chk_out("mid_h2", 4'h0, 4'h0, 4'h0, 4'h0);
    step(1, 1, 4'hD); chk_st("relock0", 2'd1, 0, 1, 0);
    step(1, 0, 4'hE); chk_st("relock1", 2'd2, 0, 1, 0);
    step(1, 0, 4'hF); chk_st("relock2", 2'd3, 0, 1, 0);
    step(1, 0, 4'h1); chk_st("relock3", 2'd0, 1, 1, 0);
                      chk_out("relock3", 4'hD, 4'hE, 4'hF, 4'h1);
    step(0, 0, 4'h0); chk_st("end", 2'd0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
